// File: rtl/counter_loop_pkg.sv
// counter_loop_pkg
// Shared definitions for the counter_loop slice: the direction type used by
// the optional ping-pong FSM and the parameter legality check evaluated at
// elaboration by the top level.
// Optional feature macro: COUNTER_LOOP_PINGPONG_EN (consumed by the users of
// this package, not by the package itself).
// Ports: none (package).

`timescale 1ns/1ps

package counter_loop_pkg;

   // Counting direction; only meaningful when the ping-pong build is enabled.
   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

   // True when the parameter set describes a loop the counter can realise:
   // width 2..32, 0 <= start < end <= 2**width-1 and 1 <= step <= end-start.
   // The width is validated before the shift so the maximum value never
   // overflows the 64-bit arithmetic.
   function automatic bit params_legal(input int     width,
                                       input longint start_v,
                                       input longint end_v,
                                       input longint step_v);
      longint max_v;
      if (width < 2 || width > 32) begin
         return 1'b0;
      end
      max_v = (longint'(1) << width) - 1;
      return (start_v >= 0) && (start_v < end_v) && (end_v <= max_v) &&
             (step_v >= 1) && (step_v <= end_v - start_v);
   endfunction

endpackage

// File: rtl/counter_loop_next.sv
// counter_loop_next
// Purely combinational next-state logic for counter_loop. Given the current
// count (and, in the ping-pong build, the current direction) it produces the
// value and direction the registers take on the next rising edge.
// Optional feature macro: COUNTER_LOOP_PINGPONG_EN
//   undefined : wrap mode, START..END then back to START
//   defined   : ping-pong mode, START..END..START with a direction FSM
// Ports:
//   y        in  WIDTH  current count
//   dir      in  1      current direction (ping-pong build only)
//   dir_next out 1      next direction    (ping-pong build only)
//   y_next   out WIDTH  next count

`timescale 1ns/1ps

module counter_loop_next
   import counter_loop_pkg::*;
#(
   parameter int     WIDTH = 4,
   parameter longint START = 0,
   parameter longint END   = (longint'(1) << WIDTH) - 1,
   parameter longint STEP  = 1
) (
   input  logic [WIDTH-1:0] y,
`ifdef COUNTER_LOOP_PINGPONG_EN
   input  dir_t             dir,
   output dir_t             dir_next,
`endif
   output logic [WIDTH-1:0] y_next
);

   localparam logic [WIDTH:0]   START_W = (WIDTH+1)'(START);
   localparam logic [WIDTH:0]   END_W   = (WIDTH+1)'(END);
   localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] START_Y = WIDTH'(START);

   logic [WIDTH:0] to_end;
   logic [WIDTH:0] up_sum;

   // Distance to the top of the loop and the tentative incremented value.
   // Both are one bit wider than the count: y never exceeds END, so the
   // subtraction cannot go negative, and y + STEP cannot wrap before the
   // comparison decides whether it is used.
   assign to_end = END_W - {1'b0, y};
   assign up_sum = {1'b0, y} + STEP_W;

`ifdef COUNTER_LOOP_PINGPONG_EN

   localparam logic [WIDTH-1:0] END_Y = WIDTH'(END);

   logic [WIDTH:0] from_start;
   logic [WIDTH:0] down_diff;

   // Distance above the bottom of the loop and the tentative decremented
   // value, used only while counting down.
   assign from_start = {1'b0, y} - START_W;
   assign down_diff  = {1'b0, y} - STEP_W;

   // Ping-pong direction FSM. Climbing, the last step is clamped onto END
   // and the direction flips; descending, the last step is clamped onto
   // START and the direction flips back. Clamping onto the endpoint rather
   // than overshooting is what makes each endpoint appear exactly once per
   // turn.
   always_comb begin
      y_next   = WIDTH'(up_sum);
      dir_next = dir;
      if (dir == UP) begin
         if (to_end <= STEP_W) begin
            y_next   = END_Y;
            dir_next = DOWN;
         end
      end else begin
         if (from_start <= STEP_W) begin
            y_next   = START_Y;
            dir_next = UP;
         end else begin
            y_next   = WIDTH'(down_diff);
         end
      end
   end

`else

   // Wrap mode. When a full step no longer fits below END the partial step
   // is thrown away and the loop restarts at exactly START on the same edge.
   always_comb begin
      y_next = WIDTH'(up_sum);
      if (to_end < STEP_W) begin
         y_next = START_Y;
      end
   end

`endif

endmodule

// File: rtl/counter_loop.sv
// counter_loop
// Free-running self-looping up counter with a registered output. After reset
// it advances by STEP on every rising clock edge and loops from END back to
// START. There is no enable and no synchronous clear.
// Optional feature macro: COUNTER_LOOP_PINGPONG_EN
//   undefined : wrap mode, no direction register
//   defined   : ping-pong mode, adds a direction register reset to UP
// Parameters: WIDTH (2..32), START, END (inclusive), STEP; illegal sets stop
// elaboration with a fatal error.
// Ports:
//   clk  in  1      rising-edge clock
//   rst  in  1      asynchronous active-low reset (externally synchronised)
//   y    out WIDTH  current count, straight from a register

`timescale 1ns/1ps

module counter_loop
   import counter_loop_pkg::*;
#(
   parameter int     WIDTH = 4,
   parameter longint START = 0,
   parameter longint END   = (longint'(1) << WIDTH) - 1,
   parameter longint STEP  = 1
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] y
);

   localparam logic [WIDTH-1:0] START_Y = WIDTH'(START);

   // Refuse to build a counter whose loop cannot be realised, e.g. a zero
   // step or a start value at or above the end value.
   generate
      if (!params_legal(WIDTH, START, END, STEP)) begin : g_bad_params
         $fatal(1, "counter_loop: illegal parameters WIDTH=%0d START=%0d END=%0d STEP=%0d",
                WIDTH, START, END, STEP);
      end
   endgenerate

   logic [WIDTH-1:0] y_next;

`ifdef COUNTER_LOOP_PINGPONG_EN

   dir_t dir;
   dir_t dir_next;

   counter_loop_next #(
      .WIDTH (WIDTH),
      .START (START),
      .END   (END),
      .STEP  (STEP)
   ) u_next (
      .y        (y),
      .dir      (dir),
      .dir_next (dir_next),
      .y_next   (y_next)
   );

   // Direction state register. Reset always restarts the climb, whichever
   // half of the turn the counter was in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dir <= UP;
      end else begin
         dir <= dir_next;
      end
   end

`else

   counter_loop_next #(
      .WIDTH (WIDTH),
      .START (START),
      .END   (END),
      .STEP  (STEP)
   ) u_next (
      .y      (y),
      .y_next (y_next)
   );

`endif

   // Count register. Reset forces START immediately, independent of the
   // clock; once released, every rising edge loads the precomputed next
   // value, so the first edge after release already yields START+STEP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y <= START_Y;
      end else begin
         y <= y_next;
      end
   end

endmodule

// File: tb/tb_counter_loop.sv
// tb_counter_loop
// Self-checking bench for counter_loop. Two instances share clock and reset:
// the default configuration and an odd-step configuration (START=2, END=11,
// STEP=4). Expected counts come from a closed-form model of the loop.
// Optional feature macro: COUNTER_LOOP_PINGPONG_EN selects the ping-pong
// model to match the design build.
// Ports: none (testbench top).

`timescale 1ns/1ps

module tb_counter_loop;

   localparam longint O_START = 2;
   localparam longint O_END   = 11;
   localparam longint O_STEP  = 4;

   logic       clk;
   logic       rst;
   logic [3:0] y;
   logic [3:0] y_odd;

   int checks;
   int failures;
   int k;

   counter_loop dut (
      .clk (clk),
      .rst (rst),
      .y   (y)
   );

   counter_loop #(
      .WIDTH (4),
      .START (O_START),
      .END   (O_END),
      .STEP  (O_STEP)
   ) dut_odd (
      .clk (clk),
      .rst (rst),
      .y   (y_odd)
   );

   // 20 ns clock, rising edges at 10, 30, 50, ...
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   // Value expected n rising edges after reset release, computed from the
   // shape of the loop rather than by stepping any state machine.
   function automatic logic [3:0] expect_y(input longint s, input longint e,
                                           input longint st, input int n);
`ifdef COUNTER_LOOP_PINGPONG_EN
      longint n_up;
      longint idx;
      n_up = (e - s + st - 1) / st;
      idx  = longint'(n) % (2 * n_up);
      if (idx < n_up) begin
         return 4'(s + idx * st);
      end
      if (idx == n_up) begin
         return 4'(e);
      end
      return 4'(e - (idx - n_up) * st);
`else
      longint period;
      period = (e - s) / st + 1;
      return 4'(s + (longint'(n) % period) * st);
`endif
   endfunction

   // Reset assertion and release, then the first four counted edges.
   task automatic test_reset();
      logic [3:0] exp;
      rst = 1'b1;
      #50 rst = 1'b0;
      #1;
      checks++;
      if (y !== 4'd0) begin
         failures++;
         $display("[TB] FAIL reset_assert: y=%0d required 0", y);
      end
      checks++;
      if (y_odd !== 4'd2) begin
         failures++;
         $display("[TB] FAIL reset_assert_odd: y_odd=%0d required 2", y_odd);
      end
      #24;
      checks++;
      if (y !== 4'd0) begin
         failures++;
         $display("[TB] FAIL reset_hold: y=%0d required 0", y);
      end
      #25 rst = 1'b1;
      k = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         k++;
         exp = expect_y(0, 15, 1, k);
         checks++;
         if (y !== exp) begin
            failures++;
            $display("[TB] FAIL reset_release_edge%0d: y=%0d required %0d", k, y, exp);
         end
      end
      checks++;
      if (y !== 4'd4) begin
         failures++;
         $display("[TB] FAIL four_edges: y=%0d required 4", y);
      end
   endtask

   // Continue to 17 edges after release, crossing the loop turn-around.
   task automatic test_wrap();
      logic [3:0] exp;
      logic [3:0] exp_o;
      while (k < 17) begin
         @(posedge clk);
         @(negedge clk);
         k++;
         exp   = expect_y(0, 15, 1, k);
         exp_o = expect_y(O_START, O_END, O_STEP, k);
         checks++;
         if (y !== exp) begin
            failures++;
            $display("[TB] FAIL wrap_edge%0d: y=%0d required %0d", k, y, exp);
         end
         checks++;
         if (y_odd !== exp_o) begin
            failures++;
            $display("[TB] FAIL wrap_odd_edge%0d: y_odd=%0d required %0d", k, y_odd, exp_o);
         end
      end
   endtask

   // Run until y hits target (descending only if want_down), then assert
   // reset between edges, hold it two edges, release and see the restart.
   task automatic test_midrun_reset(input logic [3:0] target, input bit want_down);
      logic [3:0] exp;
      logic [3:0] prev;
      bit         found;
      found = 1'b0;
      prev  = y;
      for (int i = 0; i < 64 && !found; i++) begin
         @(posedge clk);
         @(negedge clk);
         k++;
         exp = expect_y(0, 15, 1, k);
         checks++;
         if (y !== exp) begin
            failures++;
            $display("[TB] FAIL midrun_run_edge%0d: y=%0d required %0d", k, y, exp);
         end
         found = (y == target) && (!want_down || prev > y);
         prev  = y;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("[TB] FAIL midrun_target_timeout: y=%0d required %0d within 64 edges", y, target);
      end
      #5 rst = 1'b0;
      #1;
      checks++;
      if (y !== 4'd0) begin
         failures++;
         $display("[TB] FAIL midrun_assert: y=%0d required 0", y);
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (y !== 4'd0 || y_odd !== 4'd2) begin
            failures++;
            $display("[TB] FAIL midrun_hold: y=%0d y_odd=%0d required 0 and 2", y, y_odd);
         end
      end
      rst = 1'b1;
      k = 0;
      @(posedge clk);
      @(negedge clk);
      k++;
      checks++;
      if (y !== 4'd1) begin
         failures++;
         $display("[TB] FAIL midrun_restart: y=%0d required 1", y);
      end
   endtask

   // Odd step from a fresh reset: the loop must stay inside [2, 11].
   task automatic test_odd_step();
      logic [3:0] exp_o;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (y_odd !== 4'd2) begin
         failures++;
         $display("[TB] FAIL odd_reset: y_odd=%0d required 2", y_odd);
      end
      @(negedge clk);
      rst = 1'b1;
      k = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         @(negedge clk);
         k++;
         exp_o = expect_y(O_START, O_END, O_STEP, k);
         checks++;
         if (y_odd !== exp_o) begin
            failures++;
            $display("[TB] FAIL odd_step_edge%0d: y_odd=%0d required %0d", k, y_odd, exp_o);
         end
         checks++;
         if (y_odd < 4'd2 || y_odd > 4'd11) begin
            failures++;
            $display("[TB] FAIL odd_step_range: y_odd=%0d required within 2..11", y_odd);
         end
      end
   endtask

   // Random run lengths interleaved with random mid-cycle reset pulses.
   task automatic test_random();
      logic [3:0] exp;
      logic [3:0] exp_o;
      int         run;
      int         hold;
      for (int it = 0; it < 25; it++) begin
         run = int'($urandom_range(1, 40));
         for (int i = 0; i < run; i++) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            exp   = expect_y(0, 15, 1, k);
            exp_o = expect_y(O_START, O_END, O_STEP, k);
            checks++;
            if (y !== exp || y_odd !== exp_o) begin
               failures++;
               $display("[TB] FAIL random_run it%0d edge%0d: y=%0d y_odd=%0d required %0d and %0d",
                        it, k, y, y_odd, exp, exp_o);
            end
         end
         #($urandom_range(1, 8)) rst = 1'b0;
         #1;
         checks++;
         if (y !== 4'd0 || y_odd !== 4'd2) begin
            failures++;
            $display("[TB] FAIL random_reset it%0d: y=%0d y_odd=%0d required 0 and 2", it, y, y_odd);
         end
         hold = int'($urandom_range(0, 2));
         @(negedge clk);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
         end
         checks++;
         if (y !== 4'd0 || y_odd !== 4'd2) begin
            failures++;
            $display("[TB] FAIL random_hold it%0d: y=%0d y_odd=%0d required 0 and 2", it, y, y_odd);
         end
         rst = 1'b1;
         k = 0;
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      k        = 0;
      rst      = 1'b1;
      $display("[TB] counter_loop bench start");
      test_reset();
      test_wrap();
`ifdef COUNTER_LOOP_PINGPONG_EN
      test_midrun_reset(4'd7, 1'b1);
`else
      test_midrun_reset(4'd9, 1'b0);
`endif
      test_odd_step();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/counter_loop.md
# counter_loop

Free-running, self-looping up counter with a registered output and no control inputs beyond clock and reset. After reset it advances by a fixed step on every rising clock edge and loops from a configurable end value back to a configurable start value. It serves as a sequence source for lab-level sequential designs and as a heartbeat/index generator in larger designs.

## Interface
- WIDTH, 4: counter and output width in bits; legal range 2..32.
- START, 0: reset value and loop start value; requires 0 <= START < END.
- END, 2**WIDTH-1: loop end value, inclusive; requires END <= 2**WIDTH-1.
- STEP, 1: increment per clock edge; requires 1 <= STEP <= END-START.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset.
- y  output  WIDTH  current count; driven directly from a register.

## Operation
- While rst = 0: y = START and the direction state = UP, both immediately and independent of clk.
- Wrap mode, the default build: on each rising clk edge with rst = 1:
  - if END - y < STEP, then y <= START;
  - otherwise y <= y + STEP.
  - Defaults give 0,1,...,15,0,1,...
- The counter never leaves [START, END]. It never overshoots END; a partial final step is discarded, and the loop restarts at exactly START.
- All comparisons are evaluated as END - y with no risk of overflow; y + STEP is formed at WIDTH+1 bits.
- Parameter legality is checked at elaboration with a fatal error on violation.
- The counter has no enable and no synchronous clear; it counts on every edge outside reset.

## Timing
- Latency is one cycle: the first rising edge with rst = 1 yields START+STEP.
- Reset assertion takes effect asynchronously mid-cycle. Release is sampled at the next rising edge, and that edge already counts.
- When reset is released coincident with a clk edge, the count stays at START for that edge. rst is expected to be synchronized externally.
- Wrap happens in a single edge: END -> START, with no intermediate or hold cycle.
- Period of the sequence in wrap mode: floor((END-START)/STEP)+1 cycles.

## Configuration
- Macro COUNTER_LOOP_PINGPONG_EN.
- Undefined: wrap mode as above. The direction register is absent, or tied to UP and optimized away.
- Defined: two-state direction FSM {UP, DOWN}, reset to UP.
  - In UP: if END - y <= STEP, then y <= END and the state goes to DOWN; otherwise y <= y + STEP.
  - In DOWN: if y - START <= STEP, then y <= START and the state goes to UP; otherwise y <= y - STEP.
  - Defaults give 0..15,14..1,0,1,...
  - Endpoints appear once per turn. Reset in either state returns to START/UP.

## Structure
- Package counter_loop_pkg holds:
  - the direction typedef (enum UP = 1'b0, DOWN = 1'b1);
  - a function returning the legal-parameter check.
- One sub-module, counter_loop_next: purely combinational. It computes the next y and next direction from the current y and direction for the given START/END/STEP.
- The top level holds only the registers, the async reset and the elaboration checks.

## Test plan
- Reset: clk period 20 ns; drive rst = 0 at 50 ns -> y = 0 immediately. Release at 100 ns -> y = 1 after the first edge and y = 4 after four edges.
- Wrap, defaults: run 17 edges after release -> y reads 1..15, then 0, then 1.
- Mid-run reset: assert rst = 0 between edges while y = 9 -> y = 0 within the same cycle and held until release. Then restart at 1.
- Odd step, WIDTH = 4, START = 2, END = 11, STEP = 4 -> 2, 6, 10, 2, 6, with no 14 or overshoot.
- Ping-pong, with COUNTER_LOOP_PINGPONG_EN defined and defaults -> 0..15, 14..0, 1. Reset asserted during DOWN at y = 7 -> y = 0, and the next value is 1.
- Illegal parameters, STEP = 0 or START >= END -> elaboration fails with a fatal message.
